counter_seek_arbiter: RTL and testbench

Owns a WIDTH-bit up/down counter that steps by 1 or 2 per clock, and moves it to a requested target value.
Two requesters submit targets through valid/ready handshakes; a round-robin arbiter grants one request at a time.
For each granted request, the FSM picks the shorter direction around the wrap, then steps the counter until it reaches the target, then pulses done.
Used wherever the up/down step counter is a shared position/index resource.

---
 rtl/counter_ctrl_pkg.sv | 17 +
 rtl/updown_step_counter.sv | 35 +++
 rtl/counter_seek_arbiter.sv | 125 ++++++++++++
 tb/tb_counter_seek_arbiter.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/counter_ctrl_pkg.sv
// Shared types, direction constants and modular-distance helper for the seek counter.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, SEEK, DONE} state_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  // Steps needed to go upward from a to b, modulo 2**width.
  function automatic logic [31:0] distance(input logic [31:0] a, input logic [31:0] b,
                                           input int unsigned width);
    logic [31:0] mask;
    mask = (width >= 32) ? 32'hffff_ffff : ((32'd1 << width) - 32'd1);
    return (b - a) & mask;
  endfunction

endpackage

// File: rtl/updown_step_counter.sv
// Wrapping up/down counter that moves by 1 or 2 per enabled clock.
module updown_step_counter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             step2,
  input  logic             down,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q, q_d, step;

  always_comb begin
    step = step2 ? WIDTH'(2) : WIDTH'(1);
    q_d  = q_q;
    if (en) begin
      q_d = (down == DIR_DOWN) ? (q_q - step) : (q_q + step);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_seek_arbiter.sv
// Two-requester round-robin front end that seeks a shared step counter to a requested target.
module counter_seek_arbiter
  import counter_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  input  logic [WIDTH-1:0] req_target0,
  input  logic [WIDTH-1:0] req_target1,
  output logic [1:0]       req_ready,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             done_id
);

  state_e state_q, state_d;

  logic [WIDTH-1:0] tgt_q, tgt_d;
  logic             id_q, id_d;
  logic             last_q, last_d;
  logic             dir_q, dir_d;

  logic             grant;
  logic             hs;
  logic [WIDTH-1:0] sel_tgt;
  logic [WIDTH-1:0] up_dist, dn_dist;
  logic [WIDTH-1:0] rem;
  logic             cnt_en, cnt_step2;

  // Contention goes to whoever was not served last.
  always_comb begin
    grant   = (req_valid == 2'b11) ? ~last_q : req_valid[1];
    hs      = (state_q == IDLE) && (req_valid != 2'b00);
    sel_tgt = grant ? req_target1 : req_target0;
    up_dist = WIDTH'(distance(32'(count), 32'(sel_tgt), WIDTH));
    dn_dist = WIDTH'(distance(32'(sel_tgt), 32'(count), WIDTH));
    rem     = (dir_q == DIR_UP) ? WIDTH'(distance(32'(count), 32'(tgt_q), WIDTH))
                                : WIDTH'(distance(32'(tgt_q), 32'(count), WIDTH));
  end

  always_comb begin
    tgt_d  = tgt_q;
    id_d   = id_q;
    last_d = last_q;
    dir_d  = dir_q;
    if (hs) begin
      tgt_d  = sel_tgt;
      id_d   = grant;
      last_d = grant;
      dir_d  = (up_dist <= dn_dist) ? DIR_UP : DIR_DOWN;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tgt_q  <= '0;
      id_q   <= 1'b0;
      last_q <= 1'b1;
      dir_q  <= DIR_UP;
    end else begin
      tgt_q  <= tgt_d;
      id_q   <= id_d;
      last_q <= last_d;
      dir_q  <= dir_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (hs) state_d = SEEK;
      SEEK:    if (rem == '0) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready = 2'b00;
    busy      = 1'b0;
    done      = 1'b0;
    done_id   = 1'b0;
    cnt_en    = 1'b0;
    cnt_step2 = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (hs) req_ready = grant ? 2'b10 : 2'b01;
      end
      SEEK: begin
        busy      = 1'b1;
        cnt_en    = (rem != '0);
        cnt_step2 = (rem >= WIDTH'(2));
      end
      DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        done_id = id_q;
      end
      default: ;
    endcase
  end

  updown_step_counter #(
    .WIDTH(WIDTH)
  ) u_counter (
    .clk  (clk),
    .rst  (rst),
    .en   (cnt_en),
    .step2(cnt_step2),
    .down (dir_q),
    .q    (count)
  );

endmodule

// File: tb/tb_counter_seek_arbiter.sv
// Scoreboard bench: stimulus queues expected per-cycle responses, a negedge monitor checks them.
module tb_counter_seek_arbiter;

  localparam int unsigned WIDTH = 4;
  localparam int          MOD   = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] req_valid = 2'b00;
  logic [3:0] req_target0 = '0;
  logic [3:0] req_target1 = '0;
  logic [1:0] req_ready;
  logic [3:0] count;
  logic       busy, done, done_id;

  counter_seek_arbiter #(
    .WIDTH(WIDTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_target0(req_target0),
    .req_target1(req_target1),
    .req_ready  (req_ready),
    .count      (count),
    .busy       (busy),
    .done       (done),
    .done_id    (done_id)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int cyc;
    int a;
    int b;
  } ent_t;

  ent_t rdy_q[$];
  ent_t traj_q[$];
  ent_t done_q[$];

  int n_cmp = 0;
  int n_err = 0;
  int pos   = 0;
  int last  = 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rdy_q.size() > 0 && rdy_q[0].cyc == cyc) begin
      chk("req_ready", 32'(req_ready), rdy_q[0].a);
      void'(rdy_q.pop_front());
    end else begin
      chk("req_ready_quiet", 32'(req_ready), 0);
    end
    if (done_q.size() > 0 && done_q[0].cyc == cyc) begin
      chk("done", 32'(done), 1);
      chk("done_id", 32'(done_id), done_q[0].a);
      chk("done_count", 32'(count), done_q[0].b);
      void'(done_q.pop_front());
    end else begin
      chk("done_quiet", 32'(done), 0);
    end
    if (traj_q.size() > 0 && traj_q[0].cyc == cyc) begin
      chk("count", 32'(count), traj_q[0].a);
      chk("busy", 32'(busy), traj_q[0].b);
      void'(traj_q.pop_front());
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Reset in the current cycle: anything predicted from now on is void.
  task automatic do_reset();
    rst       = 1'b1;
    req_valid = 2'b00;
    while (rdy_q.size() > 0 && rdy_q[$].cyc >= cyc) void'(rdy_q.pop_back());
    while (traj_q.size() > 0 && traj_q[$].cyc >= cyc) void'(traj_q.pop_back());
    while (done_q.size() > 0 && done_q[$].cyc >= cyc) void'(done_q.pop_back());
    traj_q.push_back('{cyc, 0, 0});
    pos  = 0;
    last = 1;
    next_cycle();
    rst = 1'b0;
  endtask

  // Present a request in the current (idle) cycle; returns in the first idle cycle after done.
  task automatic issue(input logic [1:0] vm, input int t0, input int t1, input int abort_k);
    int  n, g, tgt, up, dn, d, moves, dc, s;
    bit  goes_up;
    n       = cyc;
    g       = (vm == 2'b11) ? (1 - last) : (vm[1] ? 1 : 0);
    tgt     = g ? t1 : t0;
    up      = (tgt - pos + MOD) % MOD;
    dn      = (pos - tgt + MOD) % MOD;
    goes_up = (up <= dn);
    d       = goes_up ? up : dn;
    moves   = (d + 1) / 2;
    dc      = n + moves + 2;
    if (abort_k > moves) abort_k = 0;

    req_valid   = vm;
    req_target0 = 4'(t0);
    req_target1 = 4'(t1);

    rdy_q.push_back('{n, 1 << g, 0});
    for (int k = 0; k <= moves; k++) begin
      s = (2 * k < d) ? 2 * k : d;
      traj_q.push_back('{n + 1 + k, (pos + (goes_up ? s : -s) + MOD) % MOD, 1});
    end
    traj_q.push_back('{dc, tgt, 1});
    done_q.push_back('{dc, g, tgt});
    pos  = tgt;
    last = g;

    for (int c = n + 1; c <= dc; c++) begin
      next_cycle();
      if (abort_k > 0 && cyc == n + abort_k) begin
        do_reset();
        return;
      end
      // Junk on the request lines while busy must be ignored.
      req_valid   = 2'($urandom_range(0, 3));
      req_target0 = 4'($urandom);
      req_target1 = 4'($urandom);
    end
    next_cycle();
    req_valid = 2'b00;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    repeat (2) next_cycle();
    traj_q.push_back('{cyc, 0, 0});
    next_cycle();
    rst = 1'b0;
    next_cycle();

    issue(2'b01, 5, 0, 0);         // 0 -> 5: 2,4,5
    issue(2'b01, 1, 0, 0);         // 5 -> 1 downward
    next_cycle();
    issue(2'b10, 0, 14, 0);        // 1 -> 14 downward: 15,14
    issue(2'b01, 0, 0, 0);
    issue(2'b01, 8, 0, 0);         // tie goes up
    do_reset();
    issue(2'b11, 3, 9, 0);         // requester 0 first
    issue(2'b11, 12, 6, 0);        // then requester 1
    issue(2'b01, 7, 0, 0);
    issue(2'b01, 7, 0, 0);         // no move
    issue(2'b10, 0, 15, 2);        // reset mid-travel
    issue(2'b01, 3, 0, 0);

    repeat (150) begin
      repeat ($urandom_range(0, 2)) next_cycle();
      issue(2'($urandom_range(1, 3)), int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
            ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 4)) : 0);
    end

    repeat (3) next_cycle();
    chk("pending_entries", 32'(rdy_q.size() + traj_q.size() + done_q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
